// File: rtl/hs32_pkg.sv
// Shared HS32 writeback definitions: register address width, data width, queue entry layout.
package hs32_pkg;
    localparam int REG_AW = 4;
    localparam int DW     = 32;

    typedef struct packed {
        logic [REG_AW-1:0] adr;
        logic [DW-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/hs32_wbq.sv
// In-order circular writeback queue: one push and one pop per edge, head visible combinationally.
// Caller guarantees no push when full and no pop when empty; entries are also exported oldest-first.
module hs32_wbq #(
    parameter int DEPTH = 4,
    parameter int AW    = hs32_pkg::REG_AW,
    parameter int DW    = hs32_pkg::DW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [AW-1:0]                push_adr,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [AW-1:0]                head_adr,
    output logic [DW-1:0]                head_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic [DEPTH-1:0]             age_vld,
    output logic [DEPTH-1:0][AW-1:0]     age_adr,
    output logic [DEPTH-1:0][DW-1:0]     age_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic [DEPTH-1:0]           vld_q, vld_d;
    logic [DEPTH-1:0][AW-1:0]   adr_q, adr_d;
    logic [DEPTH-1:0][DW-1:0]   data_q, data_d;
    logic [PW-1:0]              idx;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        adr_d   = adr_q;
        data_d  = data_q;
        if (push) begin
            adr_d[tail_q]  = push_adr;
            data_d[tail_q] = push_data;
            vld_d[tail_q]  = 1'b1;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Payload needs no reset: vld_q gates every use of it.
    always_ff @(posedge clk) begin
        adr_q  <= adr_d;
        data_q <= data_d;
    end

    always_comb begin
        idx      = head_q;
        age_vld  = '0;
        age_adr  = '0;
        age_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx         = head_q + PW'(i);
            age_vld[i]  = vld_q[idx];
            age_adr[i]  = adr_q[idx];
            age_data[i] = data_q[idx];
        end
    end

    assign head_adr  = adr_q[head_q];
    assign head_data = data_q[head_q];
    assign count     = count_q;
endmodule

// File: rtl/hs32_wb.sv
// HS32 writeback queue: mem-over-alu arbitration, drain into RF write port when decode is idle, 1-cycle min latency.
// Producers stall when full; hazards force a drain. HS32_WB_FWD_EN adds read forwarding in place of hazards.
module hs32_wb #(
    parameter int DEPTH = 4,
    parameter int AW    = hs32_pkg::REG_AW,
    parameter int DW    = hs32_pkg::DW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [AW-1:0]          mem_adr,
    input  logic [DW-1:0]          mem_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [AW-1:0]          alu_adr,
    input  logic [DW-1:0]          alu_data,
    input  logic                   rd_req,
    input  logic [AW-1:0]          rd_adr1,
    input  logic [AW-1:0]          rd_adr2,
    output logic                   hazard,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_wadr,
    output logic [DW-1:0]          rf_din,
    output logic [$clog2(DEPTH):0] count
`ifdef HS32_WB_FWD_EN
    ,
    output logic                   fwd1_valid,
    output logic [DW-1:0]          fwd1_data,
    output logic                   fwd2_valid,
    output logic [DW-1:0]          fwd2_data
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     full, mem_acc, alu_acc, push, inc1, inc2;
    logic [AW-1:0]            in_adr;
    logic [DW-1:0]            in_data;
    logic [DEPTH-1:0]         age_vld, m1, m2;
    logic [DEPTH-1:0][AW-1:0] age_adr;
    logic [DEPTH-1:0][DW-1:0] age_data;

    assign full      = (count == CW'(DEPTH));
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_acc   = mem_valid && mem_ready;
    assign alu_acc   = alu_valid && alu_ready;
    assign push      = mem_acc || alu_acc;
    assign in_adr    = mem_acc ? mem_adr  : alu_adr;
    assign in_data   = mem_acc ? mem_data : alu_data;
    assign inc1      = push && (in_adr == rd_adr1);
    assign inc2      = push && (in_adr == rd_adr2);

    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m1[i] = age_vld[i] && (age_adr[i] == rd_adr1);
            m2[i] = age_vld[i] && (age_adr[i] == rd_adr2);
        end
    end

`ifdef HS32_WB_FWD_EN
    assign hazard     = 1'b0;
    assign rf_we      = (count != '0) && !rd_req;
    assign fwd1_valid = (|m1) || inc1;
    assign fwd2_valid = (|m2) || inc2;

    // Ages run oldest to youngest, so the last hit wins; the incoming write is younger still.
    always_comb begin
        fwd1_data = '0;
        fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m1[i]) fwd1_data = age_data[i];
            if (m2[i]) fwd2_data = age_data[i];
        end
        if (inc1) fwd1_data = in_data;
        if (inc2) fwd2_data = in_data;
    end
`else
    logic unused_age_data;

    assign unused_age_data = ^age_data;
    assign hazard = rd_req && ((|m1) || (|m2) || inc1 || inc2);
    assign rf_we  = (count != '0) && (!rd_req || hazard);
`endif

    hs32_wbq #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_wbq (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_adr  (in_adr),
        .push_data (in_data),
        .pop       (rf_we),
        .head_adr  (rf_wadr),
        .head_data (rf_din),
        .count     (count),
        .age_vld   (age_vld),
        .age_adr   (age_adr),
        .age_data  (age_data)
    );
endmodule

// File: tb/tb_hs32_wb.sv
// Directed bench for hs32_wb: stimulus pushes expected RF writes, a negedge monitor pops and compares them.
module tb_hs32_wb;
    typedef struct packed {
        logic [3:0]  adr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0, alu_valid = 1'b0, rd_req = 1'b0;
    logic [3:0]  mem_adr = '0, alu_adr = '0, rd_adr1 = '0, rd_adr2 = '0;
    logic [31:0] mem_data = '0, alu_data = '0;
    logic        mem_ready, alu_ready, hazard, rf_we;
    logic [3:0]  rf_wadr;
    logic [31:0] rf_din;
    logic [2:0]  count;
`ifdef HS32_WB_FWD_EN
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    int  n_chk = 0;
    int  n_err = 0;
    wr_t exp_q[$];
    wr_t e;

    hs32_wb dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_adr(mem_adr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_adr(alu_adr), .alu_data(alu_data),
        .rd_req(rd_req), .rd_adr1(rd_adr1), .rd_adr2(rd_adr2), .hazard(hazard),
        .rf_we(rf_we), .rf_wadr(rf_wadr), .rf_din(rf_din), .count(count)
`ifdef HS32_WB_FWD_EN
        , .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
        exp_q.push_back(wr_t'({a, d}));
    endtask

    always @(negedge clk) begin
        if (reset && rf_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_write: adr %0d data 0x%0h with nothing pending", rf_wadr, rf_din);
            end else begin
                e = exp_q.pop_front();
                chk("wr_adr", {28'd0, rf_wadr}, {28'd0, e.adr});
                chk("wr_data", rf_din, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        step();
        @(negedge clk);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_hazard", {31'd0, hazard}, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
`ifdef HS32_WB_FWD_EN
        chk("rst_fwd1_valid", {31'd0, fwd1_valid}, 32'd0);
        chk("rst_fwd2_valid", {31'd0, fwd2_valid}, 32'd0);
`endif
        step();
        reset = 1'b1;

        // Single load write, empty queue: visible the cycle after acceptance.
        step();
        mem_valid = 1'b1; mem_adr = 4'd3; mem_data = 32'hDEADBEEF;
        expect_wr(4'd3, 32'hDEADBEEF);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("t1_rf_we", {31'd0, rf_we}, 32'd1);
        chk("t1_rf_wadr", {28'd0, rf_wadr}, 32'd3);
        chk("t1_rf_din", rf_din, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("t1_count_after", {29'd0, count}, 32'd0);

        // Both producers at once: mem first, alu stalled one cycle.
        step();
        mem_valid = 1'b1; mem_adr = 4'd1; mem_data = 32'h0000_00A1;
        alu_valid = 1'b1; alu_adr = 4'd2; alu_data = 32'h0000_00B2;
        expect_wr(4'd1, 32'h0000_00A1);
        expect_wr(4'd2, 32'h0000_00B2);
        @(negedge clk);
        chk("t2_alu_ready_blocked", {31'd0, alu_ready}, 32'd0);
        chk("t2_mem_ready", {31'd0, mem_ready}, 32'd1);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("t2_alu_ready_free", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t2_second_drain", {31'd0, rf_we}, 32'd1);
        step();
        @(negedge clk);
        chk("t2_count_after", {29'd0, count}, 32'd0);

        // Decode busy: fill to DEPTH, both producers stall, then drain in order.
        step();
        rd_req = 1'b1; rd_adr1 = 4'd14; rd_adr2 = 4'd15;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_adr = 4'(6 + i); alu_data = 32'h100 + 32'(i);
            expect_wr(4'(6 + i), 32'h100 + 32'(i));
            step();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_adr = 4'd10; mem_data = 32'h10A;
        expect_wr(4'd10, 32'h10A);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t3_count_full", {29'd0, count}, 32'd4);
            chk("t3_mem_ready_full", {31'd0, mem_ready}, 32'd0);
            chk("t3_alu_ready_full", {31'd0, alu_ready}, 32'd0);
            chk("t3_rf_we_held", {31'd0, rf_we}, 32'd0);
            chk("t3_hazard", {31'd0, hazard}, 32'd0);
            step();
        end
        rd_req = 1'b0;
        @(negedge clk);
        chk("t3_drain_start", {31'd0, rf_we}, 32'd1);
        chk("t3_ready_pre_pop", {31'd0, mem_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("t3_ready_post_pop", {31'd0, mem_ready}, 32'd1);
        chk("t3_count_post_pop", {29'd0, count}, 32'd3);
        step();
        mem_valid = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("t3_count_drained", {29'd0, count}, 32'd0);

`ifndef HS32_WB_FWD_EN
        // Read-after-write hazard against a queued entry forces a drain.
        step();
        rd_req = 1'b1; rd_adr1 = 4'd14; rd_adr2 = 4'd15;
        mem_valid = 1'b1; mem_adr = 4'd5; mem_data = 32'h11;
        expect_wr(4'd5, 32'h11);
        @(negedge clk);
        chk("t4_no_hazard", {31'd0, hazard}, 32'd0);
        step();
        mem_valid = 1'b0; rd_adr1 = 4'd5;
        @(negedge clk);
        chk("t4_hazard", {31'd0, hazard}, 32'd1);
        chk("t4_forced_drain", {31'd0, rf_we}, 32'd1);
        step();
        @(negedge clk);
        chk("t4_hazard_clear", {31'd0, hazard}, 32'd0);
        chk("t4_rf_we_clear", {31'd0, rf_we}, 32'd0);
        // Hazard against the write being accepted this very cycle.
        step();
        rd_adr1 = 4'd14; rd_adr2 = 4'd7;
        alu_valid = 1'b1; alu_adr = 4'd7; alu_data = 32'h77;
        expect_wr(4'd7, 32'h77);
        @(negedge clk);
        chk("t4_hazard_incoming", {31'd0, hazard}, 32'd1);
        chk("t4_rf_we_empty", {31'd0, rf_we}, 32'd0);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t4_hazard_queued", {31'd0, hazard}, 32'd1);
        chk("t4_drain_queued", {31'd0, rf_we}, 32'd1);
        step();
        rd_req = 1'b0;
        @(negedge clk);
        chk("t4_count_after", {29'd0, count}, 32'd0);
`else
        // Forwarding: youngest queued match, then incoming write overrides.
        step();
        rd_req = 1'b1; rd_adr1 = 4'd14; rd_adr2 = 4'd15;
        mem_valid = 1'b1; mem_adr = 4'd5; mem_data = 32'h11;
        expect_wr(4'd5, 32'h11);
        step();
        mem_data = 32'h22;
        expect_wr(4'd5, 32'h22);
        step();
        mem_valid = 1'b0; rd_adr2 = 4'd5;
        @(negedge clk);
        chk("t4_fwd2_valid", {31'd0, fwd2_valid}, 32'd1);
        chk("t4_fwd2_data", fwd2_data, 32'h22);
        chk("t4_fwd1_valid", {31'd0, fwd1_valid}, 32'd0);
        chk("t4_hazard_tied", {31'd0, hazard}, 32'd0);
        chk("t4_rf_we_held", {31'd0, rf_we}, 32'd0);
        step();
        alu_valid = 1'b1; alu_adr = 4'd5; alu_data = 32'h33;
        expect_wr(4'd5, 32'h33);
        @(negedge clk);
        chk("t4_fwd2_incoming", fwd2_data, 32'h33);
        step();
        alu_valid = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        chk("t4_drain", {31'd0, rf_we}, 32'd1);
        repeat (4) step();
        @(negedge clk);
        chk("t4_count_after", {29'd0, count}, 32'd0);
`endif

        // Reset with pending writes: none of them may ever reach the file.
        step();
        rd_req = 1'b1; rd_adr1 = 4'd14; rd_adr2 = 4'd15;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_adr = 4'(10 + i); mem_data = 32'hBAD0 + 32'(i);
            step();
        end
        mem_valid = 1'b0;
        @(negedge clk);
        chk("t5_count_pending", {29'd0, count}, 32'd3);
        step();
        reset = 1'b0;
        rd_req = 1'b0;
        #1;
        chk("t5_count_async", {29'd0, count}, 32'd0);
        chk("t5_rf_we_async", {31'd0, rf_we}, 32'd0);
        chk("t5_mem_ready_async", {31'd0, mem_ready}, 32'd1);
        step();
        reset = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk("t5_count_final", {29'd0, count}, 32'd0);

        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
